mem_port_arbiter: RTL and testbench

- Two-requester arbiter for the single shared 32-bit memory port.
- Requester 0 is the instruction-fetch side; requester 1 is the data-access side.
- Owns the select line of the two mux_32_bit instances that steer address and write data onto the port.
- Sequences one transaction at a time. Uses round-robin priority with a bounded burst length so neither side starves.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 32-bit memory port: fetch (0) vs data (1),
// one transaction at a time, with a bounded burst so neither side starves.

module mux_32_bit (
   input  logic        sel,
   input  logic [31:0] in_0,
   input  logic [31:0] in_1,
   output logic [31:0] y
);
   assign y = sel ? in_1 : in_0;
endmodule

module mem_port_arbiter #(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_0,
   input  logic        req_1,
   input  logic [31:0] addr_0,
   input  logic [31:0] addr_1,
   input  logic [31:0] wdata_0,
   input  logic [31:0] wdata_1,
   input  logic        write_0,
   input  logic        write_1,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        gnt_0,
   output logic        gnt_1,
   output logic        ack_0,
   output logic        ack_1,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        select
);
   typedef enum logic [1:0] {IDLE, BUSY_0, BUSY_1} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state;
   logic             last;
   logic [CNT_W-1:0] burst_cnt;
   logic             own_req;
   logic             oth_req;

   // In a BUSY state select always names the owner, so it doubles as the owner index.
   assign own_req = select ? req_1 : req_0;
   assign oth_req = select ? req_0 : req_1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         select    <= 1'b0;
         last      <= 1'b1;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // On a tie, the side not served last wins.
               if (req_0 && (!req_1 || last)) begin
                  state     <= BUSY_0;
                  select    <= 1'b0;
                  burst_cnt <= '0;
               end else if (req_1) begin
                  state     <= BUSY_1;
                  select    <= 1'b1;
                  burst_cnt <= '0;
               end
            end
            BUSY_0, BUSY_1: begin
               if (mem_ready) begin
                  if (oth_req && (!own_req || burst_cnt == HOLD_LAST)) begin
                     state     <= select ? BUSY_0 : BUSY_1;
                     select    <= ~select;
                     burst_cnt <= '0;
                     last      <= select;
                  end else if (own_req) begin
                     // Saturate while the other side is quiet; no wrap-around.
                     if (burst_cnt != HOLD_LAST)
                        burst_cnt <= burst_cnt + CNT_W'(1);
                  end else begin
                     state     <= IDLE;
                     burst_cnt <= '0;
                     last      <= select;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               select    <= 1'b0;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   assign gnt_0   = (state == BUSY_0);
   assign gnt_1   = (state == BUSY_1);
   assign mem_req = gnt_0 | gnt_1;

   // A transaction caught by reset is abandoned, so it must not ack.
   assign ack_0 = gnt_0 & mem_ready & ~rst;
   assign ack_1 = gnt_1 & mem_ready & ~rst;
   assign rdata = mem_rdata;

   mux_32_bit u_addr_mux (
      .sel  (select),
      .in_0 (addr_0),
      .in_1 (addr_1),
      .y    (mem_addr)
   );

   mux_32_bit u_wdata_mux (
      .sel  (select),
      .in_0 (wdata_0),
      .in_1 (wdata_1),
      .y    (mem_wdata)
   );

   assign mem_write = select ? write_1 : write_0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by contract-abiding random traffic, all checked
// against a transaction-level model of the arbitration rules.

module tb_mem_port_arbiter;
   localparam int HOLD_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_0, req_1;
   logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
   logic        write_0, write_1;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        gnt_0, gnt_1, ack_0, ack_1;
   logic [31:0] rdata;
   logic        mem_req;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_write;
   logic        select;

   always #5 clk = ~clk;

   mem_port_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_0     (req_0),
      .req_1     (req_1),
      .addr_0    (addr_0),
      .addr_1    (addr_1),
      .wdata_0   (wdata_0),
      .wdata_1   (wdata_1),
      .write_0   (write_0),
      .write_1   (write_1),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .gnt_0     (gnt_0),
      .gnt_1     (gnt_1),
      .ack_0     (ack_0),
      .ack_1     (ack_1),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .select    (select)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: who owns the port, who was served last, and how many completions
   // the current owner has taken back to back.
   bit m_busy   = 1'b0;
   int m_who    = 0;
   bit m_sel    = 1'b0;
   int m_last   = 1;
   int m_streak = 0;
   bit p_ack0   = 1'b0;
   bit p_ack1   = 1'b0;
   bit p_rst    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit r[2];
      r[0] = req_0;
      r[1] = req_1;
      if (rst) begin
         m_busy = 0; m_sel = 0; m_last = 1; m_streak = 0;
      end else if (!m_busy) begin
         if (r[0] || r[1]) begin
            m_who    = (r[0] && r[1]) ? 1 - m_last : (r[1] ? 1 : 0);
            m_busy   = 1;
            m_sel    = m_who[0];
            m_streak = 0;
         end
      end else if (mem_ready) begin
         m_streak++;
         if (r[1-m_who] && (!r[m_who] || m_streak >= HOLD_MAX)) begin
            m_last   = m_who;
            m_who    = 1 - m_who;
            m_sel    = m_who[0];
            m_streak = 0;
         end else if (!r[m_who]) begin
            m_last   = m_who;
            m_busy   = 0;
            m_streak = 0;
         end
      end
   endtask

   task automatic check_all();
      bit e_g0, e_g1, e_a0, e_a1;
      e_g0 = m_busy && m_who == 0;
      e_g1 = m_busy && m_who == 1;
      e_a0 = e_g0 && mem_ready && !rst;
      e_a1 = e_g1 && mem_ready && !rst;
      chk("gnt_0", gnt_0, e_g0);
      chk("gnt_1", gnt_1, e_g1);
      chk("ack_0", ack_0, e_a0);
      chk("ack_1", ack_1, e_a1);
      chk("mem_req", mem_req, e_g0 | e_g1);
      chk("select", select, m_sel);
      chk("mem_addr", mem_addr, m_sel ? addr_1 : addr_0);
      chk("mem_wdata", mem_wdata, m_sel ? wdata_1 : wdata_0);
      chk("mem_write", mem_write, m_sel ? write_1 : write_0);
      chk("rdata", rdata, mem_rdata);
      p_ack0 = e_a0;
      p_ack1 = e_a1;
      p_rst  = rst;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic settle();
      #1;
      check_all();
   endtask

   initial begin
      int n_ack, gap;
      bit seen, hit;

      // Reset with both requests high, then first grant.
      rst = 1; req_0 = 1; req_1 = 1; mem_ready = 0; mem_rdata = 0;
      addr_0 = 32'h0000_0040; addr_1 = 32'h1000_0000;
      wdata_0 = 0; wdata_1 = 0; write_0 = 0; write_1 = 0;
      tick(); settle();
      tick(); settle();
      chk("rst_gnt_0", gnt_0, 0);
      chk("rst_gnt_1", gnt_1, 0);
      chk("rst_select", select, 0);
      rst = 0; settle();
      tick(); settle();
      chk("first_gnt_0", gnt_0, 1);
      chk("first_addr", mem_addr, 32'h0000_0040);
      mem_ready = 1; req_0 = 0; req_1 = 0; settle();
      tick(); mem_ready = 0; settle();

      // Lone requester 1 write.
      req_1 = 1; write_1 = 1; wdata_1 = 32'hAAAA_AAAA; settle();
      n_ack = 0;
      tick(); settle();
      chk("w1_select", select, 1);
      chk("w1_write", mem_write, 1);
      chk("w1_wdata", mem_wdata, 32'hAAAA_AAAA);
      n_ack += int'(ack_1);
      tick(); settle(); n_ack += int'(ack_1);
      tick(); mem_ready = 1; req_1 = 0; settle(); n_ack += int'(ack_1);
      tick(); mem_ready = 0; settle(); n_ack += int'(ack_1);
      chk("w1_ack_count", n_ack, 1);
      chk("w1_gnt_off", gnt_1, 0);

      // Burst limit: requester 0 streams, requester 1 waits.
      req_0 = 1; req_1 = 1; write_0 = 0; mem_ready = 1; settle();
      n_ack = 0; gap = 0; seen = 0; hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick(); settle();
         if (gnt_1) hit = 1;
         else if (gnt_0) begin n_ack += int'(ack_0); seen = 1; end
         else if (seen) gap++;
      end
      chk("burst_reached_gnt_1", hit, 1);
      chk("burst_ack_0_count", n_ack, HOLD_MAX);
      chk("burst_no_bubble", gap, 0);
      req_0 = 0; req_1 = 0; settle();
      tick(); mem_ready = 0; settle();

      // Tie after requester 0 was served last goes to requester 1, then alternates.
      req_0 = 1; mem_ready = 1; settle();
      tick(); req_0 = 0; settle();
      tick(); mem_ready = 0; settle();
      req_0 = 1; req_1 = 1; settle();
      tick(); settle();
      chk("tie_gnt_1", gnt_1, 1);
      chk("tie_gnt_0", gnt_0, 0);
      mem_ready = 1; req_1 = 0; settle();
      tick(); mem_ready = 0; settle();
      chk("alt_gnt_0", gnt_0, 1);

      // Early drop of req_0: grant holds until memory completes.
      req_0 = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("hold_gnt_0", gnt_0, 1);
         tick();
      end
      mem_ready = 1; mem_rdata = 32'h1234_5678; settle();
      chk("hold_ack_0", ack_0, 1);
      chk("hold_rdata", rdata, 32'h1234_5678);
      tick(); mem_ready = 0; settle();

      // Reset during a completing BUSY_1 cycle.
      req_1 = 1; settle();
      tick(); settle();
      rst = 1; mem_ready = 1; settle();
      chk("rst_mid_no_ack", ack_1, 0);
      tick(); rst = 0; mem_ready = 0; req_1 = 0; settle();
      chk("rst_mid_idle", gnt_1, 0);
      chk("rst_mid_select", select, 0);
      req_0 = 1; req_1 = 1; settle();
      tick(); settle();
      chk("rst_mid_last", gnt_0, 1);
      mem_ready = 1; req_0 = 0; req_1 = 0; settle();
      tick(); mem_ready = 0; settle();

      // Random traffic honouring the requester contract.
      for (int c = 0; c < 600; c++) begin
         tick();
         if (!req_0 || p_ack0 || p_rst) begin
            req_0   = ($urandom_range(2) != 0);
            addr_0  = $urandom;
            wdata_0 = $urandom;
            write_0 = $urandom_range(1) != 0;
         end
         if (!req_1 || p_ack1 || p_rst) begin
            req_1   = ($urandom_range(2) != 0);
            addr_1  = $urandom;
            wdata_1 = $urandom;
            write_1 = $urandom_range(1) != 0;
         end
         mem_ready = $urandom_range(2) != 0;
         mem_rdata = $urandom;
         rst       = ($urandom_range(63) == 0);
         settle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
